sprite_orient_ctrl: RTL and testbench
=====================================

# sprite_orient_ctrl

Sequencer that produces reoriented copies of 8x8 sprites (3-bit pixels, 24-bit rows) for the sprite renderer: rotation by 0/90/180/270 degrees clockwise plus an optional horizontal mirror. It owns one shared 8x8 transpose unit and one flip unit, and applies them to a working register one step per cycle. It sits between the sprite ROM fetch stage and the frame-buffer writer, with valid/ready handshakes on both sides.

## Interface
- Parameters: none. Geometry is fixed by package constants (8x8 sprite, 3-bit pixel).
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  `in_sprite` and `in_orient` are valid.
- in_ready  out  1  block can accept a sprite; high only in IDLE.
- in_sprite  in  8x24  source sprite; pixel(r,c) = `in_sprite[r][c*3 +: 3]`.
- in_orient  in  3  bits [1:0] = clockwise quarter turns; bit [2] = horizontal mirror, applied before rotation.
- out_valid  out  1  `out_sprite` holds the finished result.
- out_ready  in  1  downstream accepts the result.
- out_sprite  out  8x24  reoriented sprite.
- busy  out  1  high in any state other than IDLE.

## Operation
- Accept: when `in_valid && in_ready`, latch the sprite into the working register W and latch the step plan. Later changes to `in_orient` have no effect on this job.
- Step primitives:
  - X (transpose): W'(r,c) = W(c,r).
  - H (hflip): W'(r,c) = W(r,7-c).
  - V (vflip): W'(r,c) = W(7-r,c).
- Plan, in fixed execution order: M (an H step) if mirror, then by rotation:
  - rot 0: no steps.
  - rot 1: X, H. Result out(r,c) = in(7-c,r).
  - rot 2: H, V.
  - rot 3: X, V. Result out(r,c) = in(c,7-r).
- Step count N = mirror + (rot != 0 ? 2 : 0), so N is 0..3.
- FSM states: IDLE, S_MIR, S_XP, S_HF, S_VF, DONE.
  - IDLE: on accept, go to the first planned step state, or to DONE if N = 0.
  - Each step state updates W once, then moves to the next planned state. The final step moves to DONE.
  - DONE: `out_valid` = 1. On `out_ready`, return to IDLE.
- `out_sprite` is driven from W. It is stable whenever `out_valid` is high and may change only in step states.
- No overlap between jobs: a new sprite cannot be accepted until the result has been taken, so `in_ready` = 0 in every non-IDLE state.
- Reset (including mid-job): state returns to IDLE, W is cleared to 0, the job is discarded, and no `out_valid` is issued for it.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_sprite` = 0.
- If the accepting edge is edge k, `out_valid` rises after edge k+N. Latency from acceptance is therefore 1 / 2 / 3 / 4 cycles for N = 0 / 1 / 2 / 3.
- `out_valid` stays high until the edge where `out_ready` = 1. `in_ready` rises in the cycle after that edge.
- `out_ready` asserted early (before DONE) is ignored.
- Maximum throughput: one sprite per N+2 cycles.
- A simultaneous `in_valid` during DONE with `out_ready` is not accepted in that cycle.

## Structure
- Package `sprite_pkg`:
  - Constants: SPR_DIM = 8, PIX_W = 3, ROW_W = 24.
  - Typedef: `sprite_t` = logic [7:0][23:0].
  - Typedef: `orient_t` (packed struct: mirror, rot[1:0]).
  - Enum: `orient_state_e`.
- Instantiate the team's existing 8x8 transpose module for X.
- New combinational sub-module `sprite_flip` (inputs: sprite, `h_en`, `v_en`) for the M, H and V steps.
- W next-value: mux of W, `in_sprite`, the transpose output and the flip output, selected by state.

## Test plan
- Common stimulus: pixel (0,1) = 5, all other pixels 0, so `in_sprite[0]` = 24'h000028 and all other rows are 0.
- orient 3'b000 → `out_valid` 1 cycle after accept; `out_sprite` equals the input.
- orient 3'b001 → latency 3; `out_sprite[1]` = 24'hA00000, all other rows 0.
- orient 3'b010 → latency 3; `out_sprite[7]` = 24'h140000. orient 3'b011 → latency 3; `out_sprite[6]` = 24'h000005.
- orient 3'b100 → latency 2; `out_sprite[0]` = 24'h140000. orient 3'b101 → latency 4; `out_sprite[6]` = 24'hA00000.
- Backpressure: hold `out_ready` = 0 for 5 cycles while changing `in_orient` and `in_sprite` → `out_sprite` stays stable, `in_ready` stays 0, and the result is unaffected.
- Assert `rst_n` = 0 in S_XP → next cycle `in_ready` = 1, `out_valid` = 0, `out_sprite` = 0; no stale result appears afterwards.

Source files
------------

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared geometry constants, sprite/orientation types, the sequencer state
// encoding and a helper that picks the first rotation step of a job.
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int SPR_DIM = 8;                // sprite is SPR_DIM x SPR_DIM pixels
    localparam int PIX_W   = 3;                // bits per pixel
    localparam int ROW_W   = SPR_DIM * PIX_W;  // 24-bit packed row

    // sprite[r][c*PIX_W +: PIX_W] is pixel (r,c)
    typedef logic [SPR_DIM-1:0][ROW_W-1:0] sprite_t;

    // Packs to the same bit layout as the 3-bit orient input:
    // bit 2 = mirror, bits 1:0 = clockwise quarter turns.
    typedef struct packed {
        logic       mirror;
        logic [1:0] rot;
    } orient_t;

    typedef enum logic [2:0] {
        IDLE,
        S_MIR,
        S_XP,
        S_HF,
        S_VF,
        DONE
    } orient_state_e;

    // First state of the rotation part of a plan (after any mirror step).
    // rot 1 and 3 both begin with a transpose; rot 2 begins with an hflip.
    function automatic orient_state_e rot_first(input logic [1:0] rot);
        orient_state_e st;
        case (rot)
            2'd0:    st = DONE;
            2'd2:    st = S_HF;
            default: st = S_XP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sprite_orient_ctrl_if.sv
// -----------------------------------------------------------------------------
// sprite_orient_ctrl_if
// Input and output valid/ready channels of the sprite orientation sequencer.
//   in_valid/in_ready/in_sprite/in_orient : job request from the ROM fetch
//   out_valid/out_ready/out_sprite        : result to the frame-buffer writer
//   busy                                  : sequencer is not idle
// slave  : the sequencer side
// master : the requester/consumer side
// -----------------------------------------------------------------------------
interface sprite_orient_ctrl_if;
    import sprite_pkg::*;

    logic       in_valid;
    logic       in_ready;
    sprite_t    in_sprite;
    logic [2:0] in_orient;
    logic       out_valid;
    logic       out_ready;
    sprite_t    out_sprite;
    logic       busy;

    modport slave (
        input  in_valid, in_sprite, in_orient, out_ready,
        output in_ready, out_valid, out_sprite, busy
    );

    modport master (
        output in_valid, in_sprite, in_orient, out_ready,
        input  in_ready, out_valid, out_sprite, busy
    );
endinterface

// File: rtl/sprite_flip.sv
// -----------------------------------------------------------------------------
// sprite_flip
// Combinational horizontal and/or vertical flip of an 8x8 sprite.
//   sprite_i : source sprite
//   h_en_i   : out(r,c) = in(r,7-c)
//   v_en_i   : out(r,c) = in(7-r,c)
//   sprite_o : flipped sprite (both enables give a 180 degree turn)
// -----------------------------------------------------------------------------
module sprite_flip
    import sprite_pkg::*;
(
    input  sprite_t sprite_i,
    input  logic    h_en_i,
    input  logic    v_en_i,
    output sprite_t sprite_o
);

    sprite_t h_tmp;

    for (genvar gi = 0; gi < SPR_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < SPR_DIM; gj++) begin : g_col
            assign h_tmp[gi][gj*PIX_W +: PIX_W] = h_en_i
                ? sprite_i[gi][(SPR_DIM-1-gj)*PIX_W +: PIX_W]
                : sprite_i[gi][gj*PIX_W +: PIX_W];
        end
        assign sprite_o[gi] = v_en_i ? h_tmp[SPR_DIM-1-gi] : h_tmp[gi];
    end

endmodule

// File: rtl/sprite_transpose.sv
// -----------------------------------------------------------------------------
// sprite_transpose
// Combinational 8x8 pixel transpose: out(r,c) = in(c,r).
//   sprite_i : source sprite
//   sprite_o : transposed sprite
// -----------------------------------------------------------------------------
module sprite_transpose
    import sprite_pkg::*;
(
    input  sprite_t sprite_i,
    output sprite_t sprite_o
);

    for (genvar gi = 0; gi < SPR_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < SPR_DIM; gj++) begin : g_col
            assign sprite_o[gi][gj*PIX_W +: PIX_W] = sprite_i[gj][gi*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/sprite_orient_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_orient_ctrl
// Sequencer producing a rotated (0/90/180/270 cw) and optionally mirrored copy
// of an 8x8 sprite. One transpose and one flip unit are applied to the working
// register W, one step per cycle:
//   mirror -> H ; rot1 -> X,H ; rot2 -> H,V ; rot3 -> X,V
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset (discards any job in flight)
//   bus   : job request / result handshake channels and busy flag
// -----------------------------------------------------------------------------
module sprite_orient_ctrl
    import sprite_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_orient_ctrl_if.slave   bus
);

    orient_state_e state_q, state_d;
    orient_t       plan_q, plan_d;
    sprite_t       w_q, w_d;

    orient_t       in_plan;
    sprite_t       xp_w;
    sprite_t       flip_w;
    logic          h_en;
    logic          v_en;

    assign in_plan = orient_t'(bus.in_orient);

    sprite_transpose u_transpose (
        .sprite_i (w_q),
        .sprite_o (xp_w)
    );

    sprite_flip u_flip (
        .sprite_i (w_q),
        .h_en_i   (h_en),
        .v_en_i   (v_en),
        .sprite_o (flip_w)
    );

    // Next state, plan and W mux. The plan is only captured on accept, so
    // in_orient is ignored for the rest of the job.
    always_comb begin
        state_d = state_q;
        plan_d  = plan_q;
        w_d     = w_q;
        h_en    = 1'b0;
        v_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    w_d     = bus.in_sprite;
                    plan_d  = in_plan;
                    state_d = in_plan.mirror ? S_MIR : rot_first(in_plan.rot);
                end
            end
            S_MIR: begin
                h_en    = 1'b1;
                w_d     = flip_w;
                state_d = rot_first(plan_q.rot);
            end
            S_XP: begin
                w_d     = xp_w;
                state_d = (plan_q.rot == 2'd1) ? S_HF : S_VF;
            end
            // Shared by rot 2 (first step) and rot 1 (second step).
            S_HF: begin
                h_en    = 1'b1;
                w_d     = flip_w;
                state_d = (plan_q.rot == 2'd2) ? S_VF : DONE;
            end
            S_VF: begin
                v_en    = 1'b1;
                w_d     = flip_w;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            plan_q  <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            plan_q  <= plan_d;
            w_q     <= w_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_sprite = w_q;

endmodule

// File: tb/tb_sprite_orient_ctrl.sv
module tb_sprite_orient_ctrl;
    import sprite_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_orient_ctrl_if bus();

    sprite_orient_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        sprite_t    spr;
        logic [2:0] orient;
        int         acc;
        int         n;
    } exp_t;

    exp_t exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input sprite_t act, input sprite_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: mirror (left-right) first, then rotate 90 degrees clockwise
    // rot times, operating on a plain pixel grid.
    function automatic sprite_t ref_orient(input sprite_t s, input logic [2:0] o);
        int      p [8][8];
        int      t [8][8];
        sprite_t r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                p[i][j] = int'(s[i][j*3 +: 3]);
        if (o[2]) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    t[i][j] = p[i][7-j];
            p = t;
        end
        for (int k = 0; k < int'(o[1:0]); k++) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    t[i][j] = p[7-j][i];
            p = t;
        end
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i][j*3 +: 3] = 3'(p[i][j]);
        return r;
    endfunction

    function automatic sprite_t rand_sprite();
        sprite_t s;
        for (int i = 0; i < 8; i++) s[i] = 24'($urandom());
        return s;
    endfunction

    // Monitor: pops one expectation each time out_valid rises, then checks
    // the result stays put for as long as out_valid is held.
    initial begin : monitor
        exp_t    e;
        logic    prev_v;
        sprite_t held;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                chk1("busy_vs_in_ready", bus.busy, !bus.in_ready);
                if (bus.out_valid) begin
                    chk1("in_ready_low_while_valid", bus.in_ready, 1'b0);
                    if (!prev_v) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL stale_result actual=out_valid required=no_pending_job");
                        end else begin
                            e    = exp_q.pop_front();
                            held = bus.out_sprite;
                            chk("result_sprite", bus.out_sprite, e.spr);
                            chki("latency", cyc - e.acc, e.n);
                            $display("result orient=%b steps=%0d latency=%0d out_sprite=%h",
                                     e.orient, e.n, cyc - e.acc + 1, bus.out_sprite);
                        end
                    end else begin
                        chk("stable_while_valid", bus.out_sprite, held);
                    end
                end
                prev_v = bus.out_valid;
            end
        end
    end

    task automatic do_job(input sprite_t s, input logic [2:0] o, input int hold,
                          input logic garbage, input logic early);
        exp_t e;
        int   w;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk1("in_ready_wait", bus.in_ready, 1'b1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_sprite = s;
        bus.in_orient = o;
        e.spr    = ref_orient(s, o);
        e.orient = o;
        e.acc    = cyc + 1;
        e.n      = int'(o[2]) + ((o[1:0] != 2'd0) ? 2 : 0);
        exp_q.push_back(e);
        @(negedge clk);
        chk1("in_ready_after_accept", bus.in_ready, 1'b0);
        bus.in_valid  = garbage;
        bus.out_ready = early && (hold == 0);
        w = 0;
        while (!bus.out_valid && w < 10) begin
            if (garbage) begin
                bus.in_sprite = rand_sprite();
                bus.in_orient = 3'($urandom());
            end
            @(negedge clk);
            w++;
        end
        if (!bus.out_valid) begin
            chk1("out_valid_wait", bus.out_valid, 1'b1);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            return;
        end
        repeat (hold) begin
            if (garbage) begin
                bus.in_sprite = rand_sprite();
                bus.in_orient = 3'($urandom());
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk1("in_ready_after_take", bus.in_ready, 1'b1);
        chk1("out_valid_after_take", bus.out_valid, 1'b0);
    endtask

    sprite_t    spr0;
    logic [2:0] olist [6];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sprite = '0;
        bus.in_orient = 3'd0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        spr0          = '0;
        spr0[0]       = 24'h000028;
        olist         = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

        repeat (2) @(negedge clk);
        chk1("reset_in_ready", bus.in_ready, 1'b1);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk1("reset_busy", bus.busy, 1'b0);
        chk("reset_out_sprite", bus.out_sprite, '0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (olist[i]) do_job(spr0, olist[i], 0, 1'b0, 1'b0);
        // early out_ready plus a competing in_valid while DONE
        do_job(spr0, 3'b111, 0, 1'b1, 1'b1);
        // backpressure while inputs churn
        do_job(spr0, 3'b011, 5, 1'b1, 1'b0);

        // reset while in the transpose step
        bus.in_valid  = 1'b1;
        bus.in_sprite = spr0;
        bus.in_orient = 3'b001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk1("busy_in_step", bus.busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("midreset_in_ready", bus.in_ready, 1'b1);
        chk1("midreset_out_valid", bus.out_valid, 1'b0);
        chk("midreset_out_sprite", bus.out_sprite, '0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk1("no_stale_after_reset", bus.out_valid, 1'b0);

        for (int k = 0; k < 40; k++) begin
            do_job(rand_sprite(), 3'($urandom()), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chki("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
